icache_v3: RTL and testbench

Parametrised direct-mapped instruction cache, successor to the fixed 64 KiB/16-word fetch cache. It sits between the pipeline fetch stage and the AXI instruction port. It returns a hit and its word in the same cycle, and refills a missing line with one INCR burst. It adds configurable geometry, asynchronous reset of all valid bits, and line/whole-cache invalidation driven by the pipeline.

---
 rtl/icache_pkg.sv | 59 +++++
 rtl/icache_array.sv | 34 +++
 rtl/icache_v3.sv | 190 +++++++++++++++++++
 tb/tb_icache_v3.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types, derived geometry and address-split helpers for the icache_v3 instruction cache.
package icache_pkg;

    localparam int DEF_INDEX_BITS = 10;
    localparam int DEF_LINE_WORDS = 16;

    function automatic int calc_off_bits(input int line_words);
        return $clog2(line_words * 4);
    endfunction

    function automatic int calc_tag_bits(input int index_bits, input int line_words);
        return 32 - index_bits - calc_off_bits(line_words);
    endfunction

    localparam int OFF_BITS = calc_off_bits(DEF_LINE_WORDS);
    localparam int TAG_BITS = calc_tag_bits(DEF_INDEX_BITS, DEF_LINE_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REFILL_AR,
        S_REFILL_R,
        S_FILL,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK   = 2'b00,
        ERR_AXI  = 2'b01,
        ERR_BEAT = 2'b10
    } err_t;

    // Fields are right-aligned in 32 bits so one struct serves every geometry.
    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] index;
        logic [31:0] woff;
    } addr_split_t;

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int index_bits, input int off_bits);
        return a >> (index_bits + off_bits);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] a, input int index_bits, input int off_bits);
        return (a >> off_bits) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_woff(input logic [31:0] a, input int off_bits);
        return (a >> 2) & ((32'd1 << (off_bits - 2)) - 32'd1);
    endfunction

    function automatic addr_split_t split_addr(input logic [31:0] a, input int index_bits, input int off_bits);
        addr_split_t s;
        s.tag   = addr_tag(a, index_bits, off_bits);
        s.index = addr_index(a, index_bits, off_bits);
        s.woff  = addr_woff(a, off_bits);
        return s;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag and data storage for icache_v3: asynchronous read, one whole-line write port, no reset.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int TAGW       = calc_tag_bits(DEF_INDEX_BITS, DEF_LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [INDEX_BITS-1:0]        windex,
    input  logic [TAGW-1:0]              wtag,
    input  logic [LINE_WORDS-1:0][31:0]  wline,
    input  logic [INDEX_BITS-1:0]        rindex,
    input  logic [$clog2(LINE_WORDS)-1:0] rwoff,
    output logic [TAGW-1:0]              rtag,
    output logic [31:0]                  rword
);
    localparam int NLINES = 1 << INDEX_BITS;

    logic [LINE_WORDS-1:0][31:0] data_mem [NLINES];
    logic [TAGW-1:0]             tag_mem  [NLINES];

    always_ff @(posedge clk) begin
        if (we) begin
            data_mem[windex] <= wline;
            tag_mem[windex]  <= wtag;
        end
    end

    assign rtag  = tag_mem[rindex];
    assign rword = data_mem[rindex][rwoff];

endmodule

// File: rtl/icache_v3.sv
// Direct-mapped instruction cache with single-burst AXI refill and pipeline-driven invalidation.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_EN.
module icache_v3
    import icache_pkg::*;
#(
    parameter int          INDEX_BITS = DEF_INDEX_BITS,
    parameter int          LINE_WORDS = DEF_LINE_WORDS,
    parameter logic [31:0] NOP_INSN   = 32'h0000003F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    output logic        fetch_hit,
    output logic [31:0] fetch_rdata,
    output logic        busy,
    input  logic        inval_valid,
    output logic        inval_ready,
    input  logic        inval_all,
    input  logic [31:0] inval_addr,
    input  logic        mem_start_valid,
    input  logic [31:0] mem_start_input,
    output logic        mem_i_arvalid,
    input  logic        mem_i_arready,
    output logic [31:0] mem_i_araddr,
    output logic [7:0]  mem_i_arlen,
    output logic [2:0]  mem_i_arsize,
    output logic [1:0]  mem_i_arburst,
    input  logic [31:0] mem_i_rdata,
    input  logic [1:0]  mem_i_rresp,
    input  logic        mem_i_rlast,
    input  logic        mem_i_rvalid,
    output logic        mem_i_rready,
    output logic [1:0]  error
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int OFFW   = calc_off_bits(LINE_WORDS);
    localparam int TAGW   = calc_tag_bits(INDEX_BITS, LINE_WORDS);
    localparam int WOFFW  = OFFW - 2;
    localparam int NLINES = 1 << INDEX_BITS;
    localparam logic [WOFFW:0] CNT_LAST = (WOFFW + 1)'(LINE_WORDS - 1);

    state_t                      state_q, state_d;
    err_t                        error_q, error_d;
    logic [31:0]                 mem_start_q;
    logic [31:0]                 line_addr_q;
    logic [INDEX_BITS-1:0]       idx_q;
    logic [TAGW-1:0]             tag_q;
    logic [WOFFW:0]              cnt_q;
    logic                        flag_q;
    logic [LINE_WORDS-1:0][31:0] line_buf;
    logic [NLINES-1:0]           valid_q;

    logic [31:0]           f_abs, i_abs;
    logic [INDEX_BITS-1:0] f_idx, i_idx;
    logic [TAGW-1:0]       f_tag, r_tag;
    logic [WOFFW-1:0]      f_woff;
    logic [31:0]           r_word;
    logic                  inval_fire, miss_start, fill, beat;

    assign f_abs  = mem_start_q + fetch_addr;
    assign i_abs  = mem_start_q + inval_addr;
    assign f_idx  = INDEX_BITS'(addr_index(f_abs, INDEX_BITS, OFFW));
    assign f_tag  = TAGW'(addr_tag(f_abs, INDEX_BITS, OFFW));
    assign f_woff = WOFFW'(addr_woff(f_abs, OFFW));
    assign i_idx  = INDEX_BITS'(addr_index(i_abs, INDEX_BITS, OFFW));

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .LINE_WORDS (LINE_WORDS),
        .TAGW       (TAGW)
    ) u_array (
        .clk    (clk),
        .we     (fill),
        .windex (idx_q),
        .wtag   (tag_q),
        .wline  (line_buf),
        .rindex (f_idx),
        .rwoff  (f_woff),
        .rtag   (r_tag),
        .rword  (r_word)
    );

    assign fetch_hit     = fetch_valid && (state_q == S_IDLE) && valid_q[f_idx] && (r_tag == f_tag);
    assign fetch_rdata   = fetch_hit ? r_word : NOP_INSN;
    assign busy          = (state_q != S_IDLE);
    assign inval_ready   = (state_q == S_IDLE);
    assign inval_fire    = inval_valid && inval_ready;
    assign mem_i_arvalid = (state_q == S_REFILL_AR);
    assign mem_i_araddr  = line_addr_q;
    assign mem_i_arlen   = 8'(LINE_WORDS - 1);
    assign mem_i_arsize  = 3'b010;
    assign mem_i_arburst = 2'b01;
    assign mem_i_rready  = (state_q == S_REFILL_R);
    assign beat          = mem_i_rvalid && mem_i_rready;
    assign error         = error_q;

    always_comb begin
        state_d    = state_q;
        error_d    = error_q;
        miss_start = 1'b0;
        fill       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A concurrent invalidate takes priority; the miss retries next cycle.
                if (fetch_valid && !fetch_hit && !inval_fire) begin
                    miss_start = 1'b1;
                    state_d    = S_REFILL_AR;
                end
            end
            S_REFILL_AR: if (mem_i_arready) state_d = S_REFILL_R;
            S_REFILL_R: begin
                if (beat && mem_i_rlast) begin
                    if (flag_q || (mem_i_rresp != 2'b00)) begin
                        error_d = ERR_AXI;
                        state_d = S_ERROR;
                    end else if (cnt_q != CNT_LAST) begin
                        error_d = ERR_BEAT;
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                fill    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            error_q     <= ERR_OK;
            mem_start_q <= '0;
            line_addr_q <= '0;
            idx_q       <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            if (mem_start_valid) mem_start_q <= mem_start_input;
            if (miss_start) begin
                line_addr_q <= {f_abs[31:OFFW], OFFW'(0)};
                idx_q       <= f_idx;
                tag_q       <= f_tag;
                cnt_q       <= '0;
                flag_q      <= 1'b0;
            end else if (beat) begin
                cnt_q <= cnt_q + 1'b1;
                if (mem_i_rresp != 2'b00) flag_q <= 1'b1;
            end
            if (inval_fire) begin
                if (inval_all) valid_q <= '0;
                else           valid_q[i_idx] <= 1'b0;
            end else if (fill) begin
                valid_q[idx_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat) line_buf[cnt_q[WOFFW-1:0]] <= mem_i_rdata;
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (fetch_hit)  hit_count  <= hit_count + 32'd1;
            if (miss_start) miss_count <= miss_count + 32'd1;
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_icache_v3.sv
// Directed self-checking bench for icache_v3 with a small AXI read-slave responder.
module tb_icache_v3;
    localparam logic [31:0] NOP = 32'h0000003F;

    logic        clk, rst;
    logic        fetch_valid, fetch_hit, busy;
    logic [31:0] fetch_addr, fetch_rdata;
    logic        inval_valid, inval_ready, inval_all;
    logic [31:0] inval_addr;
    logic        mem_start_valid;
    logic [31:0] mem_start_input;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp, error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // responder configuration and observations
    bit          mem_mode = 0;
    int          err_beat = -1;
    int          last_beat = 15;
    int          ar_count = 0;
    int          ar_cycle = 0;
    logic [31:0] ar_addr_seen = '0;
    logic [7:0]  ar_len_seen = '0;

    icache_v3 dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid     (fetch_valid),
        .fetch_addr      (fetch_addr),
        .fetch_hit       (fetch_hit),
        .fetch_rdata     (fetch_rdata),
        .busy            (busy),
        .inval_valid     (inval_valid),
        .inval_ready     (inval_ready),
        .inval_all       (inval_all),
        .inval_addr      (inval_addr),
        .mem_start_valid (mem_start_valid),
        .mem_start_input (mem_start_input),
        .mem_i_arvalid   (arvalid),
        .mem_i_arready   (arready),
        .mem_i_araddr    (araddr),
        .mem_i_arlen     (arlen),
        .mem_i_arsize    (arsize),
        .mem_i_arburst   (arburst),
        .mem_i_rdata     (rdata),
        .mem_i_rresp     (rresp),
        .mem_i_rlast     (rlast),
        .mem_i_rvalid    (rvalid),
        .mem_i_rready    (rready),
        .error           (error)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // AXI read slave: grants AR on the first negedge arvalid is seen, then streams beats.
    initial begin
        int phase;
        int b;
        phase = 0;
        b = 0;
        arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 0; rvalid = 0; rlast = 0; rresp = 0;
                phase = 0;
            end else begin
                case (phase)
                    0: if (arvalid) begin
                        arready = 1;
                        ar_addr_seen = araddr;
                        ar_len_seen = arlen;
                        ar_cycle = cyc;
                        ar_count++;
                        phase = 1;
                    end
                    1: begin
                        arready = 0;
                        b = 0;
                        rvalid = 1;
                        rdata = mem_mode ? (ar_addr_seen >> 2) + 32'(b) : 32'(b);
                        rresp = (b == err_beat) ? 2'b10 : 2'b00;
                        rlast = (b == last_beat);
                        phase = 2;
                    end
                    default: begin
                        if (rlast) begin
                            rvalid = 0; rlast = 0; rresp = 0;
                            phase = 0;
                        end else begin
                            b++;
                            rdata = mem_mode ? (ar_addr_seen >> 2) + 32'(b) : 32'(b);
                            rresp = (b == err_beat) ? 2'b10 : 2'b00;
                            rlast = (b == last_beat);
                        end
                    end
                endcase
            end
        end
    end

    task automatic wait_idle(input string nm);
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout: busy=%0b required 0 within 200 cycles", nm, busy);
        end
    endtask

    task automatic peek(input logic [31:0] a, input logic eh, input logic [31:0] ed, input string nm);
        fetch_valid = 1;
        fetch_addr = a;
        #1;
        checks++;
        if (fetch_hit !== eh) begin
            failures++;
            $display("FAIL %s_hit: got %0b required %0b", nm, fetch_hit, eh);
        end
        checks++;
        if (fetch_rdata !== (eh ? ed : NOP)) begin
            failures++;
            $display("FAIL %s_rdata: got %08h required %08h", nm, fetch_rdata, eh ? ed : NOP);
        end
        fetch_valid = 0;
    endtask

    task automatic fetch_miss(input logic [31:0] a, input string nm);
        @(negedge clk);
        fetch_valid = 1;
        fetch_addr = a;
        @(posedge clk);
        wait_idle(nm);
        fetch_valid = 0;
    endtask

    task automatic do_inval(input logic all, input logic [31:0] a);
        @(negedge clk);
        inval_valid = 1;
        inval_all = all;
        inval_addr = a;
        @(negedge clk);
        inval_valid = 0;
        inval_all = 0;
    endtask

    task automatic do_reset();
        fetch_valid = 0;
        inval_valid = 0;
        mem_start_valid = 0;
        err_beat = -1;
        last_beat = 15;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        fetch_valid = 1; fetch_addr = 32'h100;
        inval_valid = 0; inval_all = 0; inval_addr = 0;
        mem_start_valid = 0; mem_start_input = 0;
        #1 rst = 1;
        #1;
        checks++;
        if (error !== 2'b00 || arvalid !== 0 || rready !== 0 || araddr !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL reset_outputs: error=%0d arvalid=%0b rready=%0b araddr=%08h busy=%0b required 0/0/0/0/0",
                     error, arvalid, rready, araddr, busy);
        end
        checks++;
        if (fetch_hit !== 0 || fetch_rdata !== NOP || inval_ready !== 1) begin
            failures++;
            $display("FAIL reset_fetch: hit=%0b rdata=%08h inval_ready=%0b required 0/%08h/1",
                     fetch_hit, fetch_rdata, inval_ready, NOP);
        end
        checks++;
        if (arlen !== 8'd15 || arsize !== 3'b010 || arburst !== 2'b01) begin
            failures++;
            $display("FAIL reset_arconst: arlen=%0d arsize=%0d arburst=%0d required 15/2/1", arlen, arsize, arburst);
        end
        fetch_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_cold_fetch();
        int n0;
        mem_mode = 0;
        n0 = ar_count;
        fetch_miss(32'h100, "cold");
        checks++;
        if (ar_count !== n0 + 1 || ar_addr_seen !== 32'h100 || ar_len_seen !== 8'd15) begin
            failures++;
            $display("FAIL cold_ar: count=%0d addr=%08h len=%0d required %0d/00000100/15",
                     ar_count - n0, ar_addr_seen, ar_len_seen, 1);
        end
        peek(32'h13C, 1, 32'h0000000F, "cold_last_word");
        peek(32'h104, 1, 32'h00000001, "cold_word1");
    endtask

    task automatic test_hit_path();
        int n0;
        do_inval(1, 0);
        mem_mode = 1;
        fetch_miss(32'h100, "hitline");
        n0 = ar_count;
        peek(32'h104, 1, 32'h00000041, "hit_104");
        peek(32'h13C, 1, 32'h0000004F, "hit_13c");
        fetch_valid = 1;
        fetch_addr = 32'h104;
        @(posedge clk);
        @(negedge clk);
        fetch_valid = 0;
        @(negedge clk);
        checks++;
        if (ar_count !== n0 || busy !== 0) begin
            failures++;
            $display("FAIL hit_no_ar: new_ars=%0d busy=%0b required 0/0", ar_count - n0, busy);
        end
    endtask

    task automatic test_conflict();
        peek(32'h100, 1, 32'h00000040, "conf_pre");
        fetch_miss(32'h0001_0100, "conf_b");
        checks++;
        if (ar_addr_seen !== 32'h0001_0100) begin
            failures++;
            $display("FAIL conf_araddr: got %08h required 00010100", ar_addr_seen);
        end
        peek(32'h0001_0100, 1, 32'h0000_4040, "conf_b_hit");
        peek(32'h100, 0, 32'h0, "conf_a_evicted");
        fetch_miss(32'h100, "conf_a");
        peek(32'h100, 1, 32'h00000040, "conf_a_back");
    endtask

    task automatic test_inval();
        int base;
        @(negedge clk);
        fetch_valid = 1; fetch_addr = 32'h200;
        inval_valid = 1; inval_all = 0; inval_addr = 32'h100;
        #1;
        base = cyc;
        checks++;
        if (inval_ready !== 1 || fetch_hit !== 0) begin
            failures++;
            $display("FAIL inval_accept: inval_ready=%0b hit=%0b required 1/0", inval_ready, fetch_hit);
        end
        @(negedge clk);
        inval_valid = 0;
        #1;
        checks++;
        if (busy !== 0) begin
            failures++;
            $display("FAIL inval_priority: busy=%0b required 0", busy);
        end
        wait_idle("inval_miss");
        fetch_valid = 0;
        checks++;
        if (ar_cycle !== base + 2 || ar_addr_seen !== 32'h200) begin
            failures++;
            $display("FAIL inval_ar_delay: cycle=%0d addr=%08h required %0d/00000200", ar_cycle, ar_addr_seen, base + 2);
        end
        peek(32'h100, 0, 32'h0, "inval_line_gone");
        peek(32'h200, 1, 32'h00000080, "inval_other_hit");
        fetch_miss(32'h100, "inval_refill");
        peek(32'h100, 1, 32'h00000040, "inval_refilled");
        do_inval(1, 0);
        peek(32'h100, 0, 32'h0, "inval_all_100");
        peek(32'h200, 0, 32'h0, "inval_all_200");
    endtask

    task automatic test_mem_start();
        @(negedge clk);
        mem_start_valid = 1; mem_start_input = 32'h1000;
        @(negedge clk);
        mem_start_valid = 0;
        fetch_miss(32'h100, "ms_base");
        checks++;
        if (ar_addr_seen !== 32'h1100) begin
            failures++;
            $display("FAIL ms_araddr: got %08h required 00001100", ar_addr_seen);
        end
        peek(32'h104, 1, 32'h00000441, "ms_hit");
        @(negedge clk);
        fetch_valid = 1; fetch_addr = 32'h200;
        @(negedge clk);
        fetch_valid = 0;
        mem_start_valid = 1; mem_start_input = 32'h5000;
        @(negedge clk);
        mem_start_valid = 0;
        wait_idle("ms_change");
        checks++;
        if (ar_addr_seen !== 32'h1200) begin
            failures++;
            $display("FAIL ms_latched: got %08h required 00001200", ar_addr_seen);
        end
        @(negedge clk);
        mem_start_valid = 1; mem_start_input = 32'h1000;
        @(negedge clk);
        mem_start_valid = 0;
        peek(32'h200, 1, 32'h00000480, "ms_line_hit");
        @(negedge clk);
        mem_start_valid = 1; mem_start_input = 32'h0;
        @(negedge clk);
        mem_start_valid = 0;
    endtask

    task automatic test_async_rst();
        bit seen;
        fetch_miss(32'h100, "ar_pre");
        peek(32'h100, 1, 32'h00000040, "ar_pre_hit");
        @(negedge clk);
        fetch_valid = 1; fetch_addr = 32'h0002_0100;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (rready) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL arst_reach_r: rready=%0b required 1", rready);
        end
        #2 rst = 1;
        #1;
        checks++;
        if (arvalid !== 0 || rready !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL arst_async: arvalid=%0b rready=%0b busy=%0b required 0/0/0", arvalid, rready, busy);
        end
        fetch_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        peek(32'h100, 0, 32'h0, "arst_miss_100");
        peek(32'h0002_0100, 0, 32'h0, "arst_miss_new");
    endtask

    task automatic run_err(input int eb, input int lb, input logic [1:0] exp, input string nm);
        bit seen;
        do_reset();
        err_beat = eb;
        last_beat = lb;
        @(negedge clk);
        fetch_valid = 1; fetch_addr = 32'h100;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (error != 2'b00) seen = 1;
        end
        fetch_valid = 0;
        checks++;
        if (error !== exp) begin
            failures++;
            $display("FAIL %s_code: got %0d required %0d", nm, error, exp);
        end
        repeat (5) @(negedge clk);
        fetch_valid = 1; fetch_addr = 32'h100;
        #1;
        checks++;
        if (error !== exp || busy !== 1 || inval_ready !== 0 || fetch_hit !== 0 || arvalid !== 0) begin
            failures++;
            $display("FAIL %s_sticky: error=%0d busy=%0b inval_ready=%0b hit=%0b arvalid=%0b required %0d/1/0/0/0",
                     nm, error, busy, inval_ready, fetch_hit, arvalid, exp);
        end
        fetch_valid = 0;
        do_reset();
        #1;
        checks++;
        if (error !== 2'b00 || busy !== 0) begin
            failures++;
            $display("FAIL %s_cleared: error=%0d busy=%0b required 0/0", nm, error, busy);
        end
    endtask

    initial begin
        test_reset();
        test_cold_fetch();
        test_hit_path();
        test_conflict();
        test_inval();
        test_mem_start();
        test_async_rst();
        run_err(2, 15, 2'b01, "err_resp");
        run_err(-1, 8, 2'b10, "err_beats");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
